storage_ctrl_v2: RTL and testbench
==================================

STORAGE_CTRL_V2 -- requirements
Module: storage_ctrl_v2

Interface
REQ-001 SHALL have parameter MEM_W, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter SRAM_BYTES, default 8192, size of the on-chip SRAM region at address 0.
REQ-003 SHALL have parameter EXT_AW, default 22, external flash byte-address width.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, external-access watchdog limit in cycles.
REQ-005 Ports SHALL be:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_we  in  1  1 = write.
- req_addr  in  32  byte address.
- req_wdata  in  MEM_W  write data.
- req_be  in  MEM_W/8  byte enables.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  MEM_W  read data.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- prog_set  in  1  enter programming mode.
- prog_clr  in  1  leave programming mode.
- prog_active  out  1  programming mode active.
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_wen  out  1  SRAM write enable, active-low.
- sram_a  out  $clog2(SRAM_BYTES*8/MEM_W)  SRAM word address.
- sram_d  out  MEM_W  SRAM write data.
- sram_q  in  MEM_W  SRAM read data, valid the cycle after the access.
- ext_stb  out  1  flash-engine read strobe.
- ext_addr  out  EXT_AW  flash byte address.
- ext_stall  in  1  engine stall.
- ext_ack  in  1  engine acknowledge.
- ext_rdata  in  MEM_W  engine read data.
- eng_spi  in  3  engine {cs_n, sck, mosi}.
- prog_spi  in  3  programmer {cs_n, sck, mosi}.
- ext_spi  out  3  pad {cs_n, sck, mosi}.

Function
REQ-006 SHALL implement FSM states IDLE, SRAM_RD, SRAM_WR, EXT_REQ, EXT_WAIT, RESP, PROG.
REQ-007 req_ready SHALL be 1 only in IDLE, and only when prog_set is 0.
REQ-008 Region decode SHALL be: addr < SRAM_BYTES -> SRAM; otherwise addr < SRAM_BYTES + 2^EXT_AW -> external; anything else -> error.
REQ-009 Accepted SRAM read SHALL go IDLE->SRAM_RD, drive sram_cen=0 and sram_wen=1 for one cycle, then pass through RESP with rsp_valid=1 and rsp_rdata=sram_q; total latency is 2 cycles from acceptance.
REQ-010 SRAM write with all req_be set SHALL go IDLE->SRAM_WR with a single sram_wen=0 cycle, then RESP with rsp_err=0.
REQ-011 SRAM write with partial req_be SHALL do read-modify-write:
- SRAM_RD, then SRAM_WR.
- sram_d = enabled bytes from latched wdata, remaining bytes from sram_q.
- Latency 3 cycles.
REQ-012 SRAM write with req_be all zero SHALL respond in RESP without any SRAM access.
REQ-013 External read SHALL go EXT_REQ, holding ext_stb=1 and ext_addr=addr-SRAM_BYTES until a cycle with ext_stall=0, then EXT_WAIT until ext_ack.
REQ-014 ext_ack SHALL produce rsp_valid=1 and rsp_rdata=ext_rdata in the following cycle.
REQ-015 External writes and out-of-range requests SHALL be accepted and answered next cycle with rsp_err=1 and rsp_rdata=0, with no memory activity.
REQ-016 Request fields SHALL be latched at acceptance; input changes during a transaction are ignored.
REQ-017 prog_set SHALL be sampled only in IDLE; in-flight transactions complete first, then the FSM enters PROG.
REQ-018 In PROG:
- ext_spi=prog_spi.
- prog_active=1.
- req_ready=0.
REQ-019 prog_clr in PROG SHALL return the FSM to IDLE next cycle.
REQ-020 Simultaneous prog_set and prog_clr SHALL be resolved in favour of prog_set.
REQ-021 Outside PROG, ext_spi SHALL equal eng_spi.

Reset
REQ-022 rst=0 SHALL asynchronously force:
- FSM to IDLE.
- sram_cen=1, sram_wen=1.
- ext_stb=0.
- rsp_valid=0, rsp_err=0, rsp_rdata=0.
- prog_active=0.
- Watchdog counter to 0.
REQ-023 Reset mid-transaction SHALL abandon the transaction without a response; ext_spi selects eng_spi.

Configuration
REQ-024 With STORAGE_CTRL_TIMEOUT_EN defined:
- A counter SHALL run in EXT_REQ/EXT_WAIT.
- Reaching TIMEOUT_CYC SHALL drop ext_stb and respond with rsp_err=1, rsp_rdata=0.
- A subsequent late ext_ack SHALL be ignored.
REQ-025 Without STORAGE_CTRL_TIMEOUT_EN, the external wait SHALL be unbounded and no counter logic SHALL exist.

Structure
REQ-026 Package storage_pkg SHALL hold the FSM state enum, the region enum (SRAM/EXT/ERR) and default parameter constants.
REQ-027 The watchdog SHALL be sub-module storage_wdt (start, clear, expired), instantiated only under STORAGE_CTRL_TIMEOUT_EN.

Verification
REQ-028 Write 0xDEADBEEF, be=0xF, to 0x10, then read 0x10 -> rsp_rdata=0xDEADBEEF, 2-cycle read latency.
REQ-029 Over 0xDEADBEEF, write 0x00001200 with be=0x2 to 0x10, then read -> 0xDEAD12EF; exactly one SRAM read and one SRAM write observed.
REQ-030 Read 0x2004 with ext_stall=1 for 3 cycles then ack with 0xCAFEF00D -> ext_addr=0x4, rsp_rdata=0xCAFEF00D.
REQ-031 Write to 0x3000, and read from 0x00402000 -> each answered with rsp_err=1 one cycle after acceptance; ext_stb stays 0.
REQ-032 prog_set during an external read -> the read completes, then prog_active=1, ext_spi follows prog_spi and req_ready=0; prog_clr -> IDLE.
REQ-033 With STORAGE_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16, external read with no ack -> rsp_err=1 after 16 cycles; a later ack causes no rsp_valid.

Source files
------------

// File: rtl/storage_pkg.sv
// Shared types and defaults for the storage controller: FSM states, address regions, decode helper.
// Latency: n/a (types and a pure combinational function only).
// Backpressure: n/a.
package storage_pkg;

   localparam int unsigned DEF_MEM_W       = 32;
   localparam int unsigned DEF_SRAM_BYTES  = 8192;
   localparam int unsigned DEF_EXT_AW      = 22;
   localparam int unsigned DEF_TIMEOUT_CYC = 1024;

   typedef enum logic [2:0] {
      IDLE,
      SRAM_RD,
      SRAM_WR,
      EXT_REQ,
      EXT_WAIT,
      RESP,
      PROG
   } state_e;

   typedef enum logic [1:0] {
      REG_SRAM,
      REG_EXT,
      REG_ERR
   } region_e;

   // 64-bit compare so SRAM_BYTES + 2^EXT_AW can exceed the 32-bit address space.
   function automatic region_e decode_region(input logic [31:0]     addr,
                                             input longint unsigned sram_bytes,
                                             input int unsigned     ext_aw);
      longint unsigned a;
      a = {32'd0, addr};
      if (a < sram_bytes) return REG_SRAM;
      if (a < sram_bytes + (64'd1 << ext_aw)) return REG_EXT;
      return REG_ERR;
   endfunction

endpackage

// File: rtl/storage_wdt.sv
// External-access watchdog: counts cycles while start is high, flags expiry on the LIMIT-th cycle.
// Latency: expired is combinational on the last allowed cycle so the FSM can leave on that edge.
// Backpressure: none; clear has priority over counting.
import storage_pkg::*;

module storage_wdt #(
   parameter int unsigned LIMIT = DEF_TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // cnt holds the number of cycles already spent waiting, so the LIMIT-th cycle sees LIMIT-1.
   assign expired = start && (cnt == CW'(LIMIT - 1));

   // Count waiting cycles; hold once expired until the owner clears.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (start && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/storage_ctrl_v2.sv
// Storage controller: single-outstanding requests to on-chip SRAM (with byte RMW) or an external flash engine.
// Latency: SRAM read/full write 2, partial write 3, empty/err 1, external = grant + ack + 1 cycles.
// Backpressure: req_ready only in IDLE with prog_set low; optional watchdog under STORAGE_CTRL_TIMEOUT_EN.
import storage_pkg::*;

module storage_ctrl_v2 #(
   parameter int unsigned MEM_W       = DEF_MEM_W,
   parameter int unsigned SRAM_BYTES  = DEF_SRAM_BYTES,
   parameter int unsigned EXT_AW      = DEF_EXT_AW,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    req_valid,
   output logic                                    req_ready,
   input  logic                                    req_we,
   input  logic [31:0]                             req_addr,
   input  logic [MEM_W-1:0]                        req_wdata,
   input  logic [MEM_W/8-1:0]                      req_be,
   output logic                                    rsp_valid,
   output logic [MEM_W-1:0]                        rsp_rdata,
   output logic                                    rsp_err,
   input  logic                                    prog_set,
   input  logic                                    prog_clr,
   output logic                                    prog_active,
   output logic                                    sram_cen,
   output logic                                    sram_wen,
   output logic [$clog2(SRAM_BYTES*8/MEM_W)-1:0]   sram_a,
   output logic [MEM_W-1:0]                        sram_d,
   input  logic [MEM_W-1:0]                        sram_q,
   output logic                                    ext_stb,
   output logic [EXT_AW-1:0]                       ext_addr,
   input  logic                                    ext_stall,
   input  logic                                    ext_ack,
   input  logic [MEM_W-1:0]                        ext_rdata,
   input  logic [2:0]                              eng_spi,
   input  logic [2:0]                              prog_spi,
   output logic [2:0]                              ext_spi
);

   localparam int unsigned BW  = MEM_W / 8;
   localparam int unsigned OFF = $clog2(BW);
   localparam int unsigned SAW = $clog2(SRAM_BYTES * 8 / MEM_W);

   state_e           state;
   region_e          region;
   logic [MEM_W-1:0] wdata_q;
   logic [BW-1:0]    be_q;
   logic             rmw_q;
   logic [MEM_W-1:0] rdata_q;
   logic             rsp_sram;
   logic [MEM_W-1:0] merged;
   logic             ext_busy;
   logic             wdt_expired;

   assign region    = decode_region(req_addr, 64'(SRAM_BYTES), EXT_AW);
   assign req_ready = (state == IDLE) && !prog_set;
   assign ext_spi   = (state == PROG) ? prog_spi : eng_spi;
   assign ext_busy  = (state == EXT_REQ) || (state == EXT_WAIT);

   // SRAM read data arrives the cycle after the access, so it is passed straight through in RESP.
   assign rsp_rdata = rsp_sram ? sram_q : rdata_q;
   assign sram_d    = rmw_q ? merged : wdata_q;

   // Merge enabled bytes of the latched write data over the word just read back.
   always_comb begin
      merged = wdata_q;
      for (int i = 0; i < int'(BW); i++) begin
         if (!be_q[i]) merged[8*i +: 8] = sram_q[8*i +: 8];
      end
   end

`ifdef STORAGE_CTRL_TIMEOUT_EN
   storage_wdt #(
      .LIMIT (TIMEOUT_CYC)
   ) u_wdt (
      .clk     (clk),
      .rst     (rst),
      .start   (ext_busy),
      .clear   (!ext_busy),
      .expired (wdt_expired)
   );
`else
   // Without the watchdog the external wait is unbounded; TIMEOUT_CYC has no effect here.
   localparam bit WDT_NONE = (TIMEOUT_CYC == 0) && 1'b0;
   assign wdt_expired = WDT_NONE;
`endif

   // Main controller FSM; all strobes and response fields are registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         sram_cen    <= 1'b1;
         sram_wen    <= 1'b1;
         sram_a      <= '0;
         ext_stb     <= 1'b0;
         ext_addr    <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rdata_q     <= '0;
         rsp_sram    <= 1'b0;
         prog_active <= 1'b0;
         wdata_q     <= '0;
         be_q        <= '0;
         rmw_q       <= 1'b0;
      end else begin
         sram_cen  <= 1'b1;
         sram_wen  <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rdata_q   <= '0;
         rsp_sram  <= 1'b0;
         case (state)
            IDLE: begin
               if (prog_set) begin
                  state       <= PROG;
                  prog_active <= 1'b1;
               end else if (req_valid) begin
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  rmw_q   <= 1'b0;
                  sram_a  <= SAW'(req_addr >> OFF);
                  case (region)
                     REG_SRAM: begin
                        if (!req_we) begin
                           state    <= SRAM_RD;
                           sram_cen <= 1'b0;
                        end else if (req_be == '1) begin
                           state    <= SRAM_WR;
                           sram_cen <= 1'b0;
                           sram_wen <= 1'b0;
                        end else if (req_be == '0) begin
                           state     <= RESP;
                           rsp_valid <= 1'b1;
                        end else begin
                           state    <= SRAM_RD;
                           sram_cen <= 1'b0;
                           rmw_q    <= 1'b1;
                        end
                     end
                     REG_EXT: begin
                        if (!req_we) begin
                           state    <= EXT_REQ;
                           ext_stb  <= 1'b1;
                           ext_addr <= EXT_AW'(req_addr - 32'(SRAM_BYTES));
                        end else begin
                           state     <= RESP;
                           rsp_valid <= 1'b1;
                           rsp_err   <= 1'b1;
                        end
                     end
                     default: begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                     end
                  endcase
               end
            end
            SRAM_RD: begin
               if (rmw_q) begin
                  state    <= SRAM_WR;
                  sram_cen <= 1'b0;
                  sram_wen <= 1'b0;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_sram  <= 1'b1;
               end
            end
            SRAM_WR: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
            end
            EXT_REQ: begin
               if (wdt_expired) begin
                  state     <= RESP;
                  ext_stb   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else if (!ext_stall) begin
                  state   <= EXT_WAIT;
                  ext_stb <= 1'b0;
               end
            end
            EXT_WAIT: begin
               if (wdt_expired) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
               end else if (ext_ack) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rdata_q   <= ext_rdata;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            PROG: begin
               // A simultaneous prog_set keeps the programmer in control.
               if (prog_clr && !prog_set) begin
                  state       <= IDLE;
                  prog_active <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_storage_ctrl_v2.sv
// Directed bench for storage_ctrl_v2 with a behavioural SRAM and a hand-driven flash engine.
// Latency: responses are timed in cycles from the acceptance edge.
// Backpressure: requests are only issued when req_ready is expected high.
module tb_storage_ctrl_v2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        prog_set = 1'b0;
   logic        prog_clr = 1'b0;
   logic        prog_active;
   logic        sram_cen;
   logic        sram_wen;
   logic [10:0] sram_a;
   logic [31:0] sram_d;
   logic [31:0] sram_q = '0;
   logic        ext_stb;
   logic [21:0] ext_addr;
   logic        ext_stall = 1'b0;
   logic        ext_ack = 1'b0;
   logic [31:0] ext_rdata = '0;
   logic [2:0]  eng_spi = 3'b101;
   logic [2:0]  prog_spi = 3'b010;
   logic [2:0]  ext_spi;

   int n_chk  = 0;
   int n_fail = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   bit stb_seen = 0;

   logic [31:0] mem [0:2047];

   storage_ctrl_v2 #(
      .MEM_W       (32),
      .SRAM_BYTES  (8192),
      .EXT_AW      (22),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_be      (req_be),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .prog_set    (prog_set),
      .prog_clr    (prog_clr),
      .prog_active (prog_active),
      .sram_cen    (sram_cen),
      .sram_wen    (sram_wen),
      .sram_a      (sram_a),
      .sram_d      (sram_d),
      .sram_q      (sram_q),
      .ext_stb     (ext_stb),
      .ext_addr    (ext_addr),
      .ext_stall   (ext_stall),
      .ext_ack     (ext_ack),
      .ext_rdata   (ext_rdata),
      .eng_spi     (eng_spi),
      .prog_spi    (prog_spi),
      .ext_spi     (ext_spi)
   );

   always #5 clk = ~clk;

   // Synchronous SRAM: write or read per enabled cycle, read data one cycle later.
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_wen) begin
            mem[sram_a] <= sram_d;
            wr_cnt = wr_cnt + 1;
         end else begin
            sram_q <= mem[sram_a];
            rd_cnt = rd_cnt + 1;
         end
      end
   end

   // Sticky record of any flash strobe activity.
   always @(negedge clk) begin
      if (ext_stb) stb_seen = 1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be);
      @(negedge clk);
      req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
      #1 check_val("req_ready", req_ready, 1);
      @(posedge clk);
      #1;
      // Scramble the request fields after acceptance; the DUT must use its latched copy.
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_be = 4'h0;
      req_we = ~we;
   endtask

   task automatic wait_rsp(input int limit, output int lat, output logic [31:0] rd, output logic err);
      lat = 0; rd = '0; err = 1'b0;
      for (int c = 1; c <= limit; c++) begin
         @(negedge clk);
         if (rsp_valid && lat == 0) begin
            lat = c; rd = rsp_rdata; err = rsp_err;
         end
         if (lat != 0) break;
      end
      if (lat == 0) check_val("rsp_within_bound", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        err;
      bit          seen;

      for (int i = 0; i < 2048; i++) mem[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_sram_cen", sram_cen, 1);
      check_val("rst_sram_wen", sram_wen, 1);
      check_val("rst_ext_stb", ext_stb, 0);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_rsp_err", rsp_err, 0);
      check_val("rst_rsp_rdata", rsp_rdata, 0);
      check_val("rst_prog_active", prog_active, 0);
      check_val("rst_ext_spi", ext_spi, 3'b101);
      rst = 1'b1;
      @(negedge clk);
      check_val("idle_req_ready", req_ready, 1);

      // Full-word write then read back
      issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      wait_rsp(20, lat, rd, err);
      check_val("wr_full_lat", lat, 2);
      check_val("wr_full_err", err, 0);
      issue(1'b0, 32'h10, 32'h0, 4'hF);
      wait_rsp(20, lat, rd, err);
      check_val("rd_lat", lat, 2);
      check_val("rd_data", rd, 32'hDEAD_BEEF);
      check_val("rd_err", err, 0);

      // Partial write: read-modify-write, exactly one read and one write
      rd_cnt = 0; wr_cnt = 0;
      issue(1'b1, 32'h10, 32'h0000_1200, 4'h2);
      wait_rsp(20, lat, rd, err);
      check_val("rmw_lat", lat, 3);
      check_val("rmw_err", err, 0);
      check_val("rmw_sram_reads", rd_cnt, 1);
      check_val("rmw_sram_writes", wr_cnt, 1);
      issue(1'b0, 32'h10, 32'h0, 4'hF);
      wait_rsp(20, lat, rd, err);
      check_val("rmw_rd_data", rd, 32'hDEAD_12EF);

      // Write with no byte enables touches nothing
      rd_cnt = 0; wr_cnt = 0;
      issue(1'b1, 32'h10, 32'h1111_1111, 4'h0);
      wait_rsp(20, lat, rd, err);
      check_val("be0_lat", lat, 1);
      check_val("be0_err", err, 0);
      check_val("be0_sram_access", rd_cnt + wr_cnt, 0);
      issue(1'b0, 32'h10, 32'h0, 4'hF);
      wait_rsp(20, lat, rd, err);
      check_val("be0_rd_data", rd, 32'hDEAD_12EF);

      // External read with three stalled cycles
      ext_stall = 1'b1;
      issue(1'b0, 32'h2004, 32'h0, 4'hF);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         check_val("ext_stb_held", ext_stb, 1);
      end
      check_val("ext_addr", ext_addr, 22'h4);
      @(negedge clk);
      ext_stall = 1'b0;
      @(negedge clk);
      check_val("ext_stb_dropped", ext_stb, 0);
      check_val("ext_no_early_rsp", rsp_valid, 0);
      ext_ack = 1'b1; ext_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      ext_ack = 1'b0; ext_rdata = '0;
      check_val("ext_rsp_valid", rsp_valid, 1);
      check_val("ext_rsp_data", rsp_rdata, 32'hCAFE_F00D);
      check_val("ext_rsp_err", rsp_err, 0);
      @(negedge clk);
      check_val("ext_rsp_pulse", rsp_valid, 0);

      // External write and out-of-range read: error, no memory activity
      stb_seen = 0; rd_cnt = 0; wr_cnt = 0;
      issue(1'b1, 32'h3000, 32'h1234_5678, 4'hF);
      wait_rsp(20, lat, rd, err);
      check_val("extwr_lat", lat, 1);
      check_val("extwr_err", err, 1);
      check_val("extwr_data", rd, 0);
      issue(1'b0, 32'h0040_2000, 32'h0, 4'hF);
      wait_rsp(20, lat, rd, err);
      check_val("oor_lat", lat, 1);
      check_val("oor_err", err, 1);
      check_val("oor_data", rd, 0);
      check_val("err_no_stb", stb_seen, 0);
      check_val("err_no_sram", rd_cnt + wr_cnt, 0);

      // Programming mode requested while an external read is in flight
      issue(1'b0, 32'h2008, 32'h0, 4'hF);
      @(negedge clk);
      prog_set = 1'b1;
      @(negedge clk);
      check_val("prog_wait_inflight", prog_active, 0);
      ext_ack = 1'b1; ext_rdata = 32'h1234_ABCD;
      @(negedge clk);
      ext_ack = 1'b0;
      check_val("prog_inflight_rsp", rsp_valid, 1);
      check_val("prog_inflight_data", rsp_rdata, 32'h1234_ABCD);
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (prog_active) begin seen = 1; break; end
      end
      check_val("prog_entered", seen, 1);
      prog_set = 1'b0;
      #1;
      check_val("prog_req_ready", req_ready, 0);
      check_val("prog_spi_sel", ext_spi, 3'b010);
      prog_spi = 3'b110;
      #1;
      check_val("prog_spi_follow", ext_spi, 3'b110);
      prog_set = 1'b1; prog_clr = 1'b1;
      @(negedge clk);
      check_val("prog_set_wins", prog_active, 1);
      prog_set = 1'b0;
      @(negedge clk);
      prog_clr = 1'b0;
      check_val("prog_cleared", prog_active, 0);
      check_val("prog_exit_spi", ext_spi, 3'b101);
      check_val("prog_exit_ready", req_ready, 1);

      // Reset in the middle of an external read abandons it
      ext_stall = 1'b1;
      issue(1'b0, 32'h2010, 32'h0, 4'hF);
      @(negedge clk);
      check_val("midrst_stb_before", ext_stb, 1);
      rst = 1'b0;
      #1;
      check_val("midrst_stb", ext_stb, 0);
      check_val("midrst_spi", ext_spi, 3'b101);
      @(negedge clk);
      rst = 1'b1; ext_stall = 1'b0; ext_ack = 1'b1; ext_rdata = 32'h7777_7777;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         ext_ack = 1'b0;
         if (rsp_valid) seen = 1;
      end
      check_val("midrst_no_rsp", seen, 0);

`ifdef STORAGE_CTRL_TIMEOUT_EN
      // Watchdog: 16 cycles waiting in the external states, response on the 17th after acceptance
      issue(1'b0, 32'h2020, 32'h0, 4'hF);
      wait_rsp(40, lat, rd, err);
      check_val("tmo_lat", lat, 17);
      check_val("tmo_err", err, 1);
      check_val("tmo_data", rd, 0);
      check_val("tmo_stb", ext_stb, 0);
      ext_ack = 1'b1; ext_rdata = 32'h9999_9999;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         ext_ack = 1'b0;
         if (rsp_valid) seen = 1;
      end
      check_val("tmo_late_ack_ignored", seen, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
